// File: rtl/round_counter.sv
// Up/down round counter with start/busy/done sequencing; count updates one cycle after start/advance.
// No backpressure: abort wins over start and advance, and start is ignored while running.
module round_counter #(
    parameter int WIDTH = 7,
    parameter int LIMIT = 63,
    parameter int STEP  = 1,
    parameter int WRAP  = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             down,
    input  logic             advance,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             last,
    output logic             done,
    output logic             zero
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] LIM_W  = LIMIT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] STEP_W = STEP[WIDTH-1:0];
    localparam logic [WIDTH:0]   LIM_X  = LIMIT[WIDTH:0];
    localparam logic [WIDTH:0]   STEP_X = STEP[WIDTH:0];

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] init_q, init_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   count_x;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] dn_next;
    logic             at_term;

    // Comparisons use one extra bit so count + STEP can never alias past 2^WIDTH.
    assign count_x      = {1'b0, count_q};
    assign load_clamped = (!down && (load_val > LIM_W)) ? LIM_W : load_val;
    assign up_next      = (count_x > (LIM_X - STEP_X)) ? LIM_W : (count_q + STEP_W);
    assign dn_next      = (count_x < STEP_X) ? '0 : (count_q - STEP_W);
    assign at_term      = dir_q ? (count_q == '0) : (count_q == LIM_W);

    assign count = count_q;
    assign busy  = (state_q == S_RUN);
    assign last  = busy && at_term;
    assign done  = done_q;
    assign zero  = (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        init_d  = init_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        count_d = load_clamped;
                        init_d  = load_clamped;
                        dir_d   = down;
                    end
                end
                S_RUN: begin
                    if (advance) begin
                        if (at_term) begin
                            done_d = 1'b1;
                            if (WRAP != 0) begin
                                count_d = init_q;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            count_d = dir_q ? dn_next : up_next;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            init_q  <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            init_q  <= init_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_round_counter.sv
// Bench for round_counter: three parameterisations share one stimulus stream,
// each checked against an arithmetic pass model plus directed tables and sequences.
module tb_round_counter;

    localparam int N = 3;
    localparam int LIM = 63;

    logic       clock;
    logic       reset;
    logic       start;
    logic [6:0] load_val;
    logic       down;
    logic       advance;
    logic       abort;

    logic [6:0] count_w [N];
    logic       busy_w  [N];
    logic       last_w  [N];
    logic       done_w  [N];
    logic       zero_w  [N];

    int P_STEP [N] = '{1, 2, 1};
    int P_WRAP [N] = '{0, 0, 1};

    // Reference model: a pass is "running" with a plain integer count.
    bit m_run  [N];
    int m_cnt  [N];
    bit m_dir  [N];
    int m_init [N];
    bit m_done [N];

    int n_pass  = 0;
    int n_total = 0;

    round_counter #(.WIDTH(7), .LIMIT(LIM), .STEP(1), .WRAP(0)) u_base (
        .clock(clock), .reset(reset), .start(start), .load_val(load_val),
        .down(down), .advance(advance), .abort(abort),
        .count(count_w[0]), .busy(busy_w[0]), .last(last_w[0]),
        .done(done_w[0]), .zero(zero_w[0]));

    round_counter #(.WIDTH(7), .LIMIT(LIM), .STEP(2), .WRAP(0)) u_step2 (
        .clock(clock), .reset(reset), .start(start), .load_val(load_val),
        .down(down), .advance(advance), .abort(abort),
        .count(count_w[1]), .busy(busy_w[1]), .last(last_w[1]),
        .done(done_w[1]), .zero(zero_w[1]));

    round_counter #(.WIDTH(7), .LIMIT(LIM), .STEP(1), .WRAP(1)) u_wrap (
        .clock(clock), .reset(reset), .start(start), .load_val(load_val),
        .down(down), .advance(advance), .abort(abort),
        .count(count_w[2]), .busy(busy_w[2]), .last(last_w[2]),
        .done(done_w[2]), .zero(zero_w[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, got, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_cnt[i] = 0; m_dir[i] = 0; m_init[i] = 0; m_done[i] = 0;
        end
    endfunction

    function automatic void model_step(int i);
        int v;
        bit d;
        d = 0;
        if (abort) begin
            m_run[i] = 0;
        end else if (!m_run[i]) begin
            if (start) begin
                v = int'(load_val);
                if (!down && v > LIM) v = LIM;
                m_run[i] = 1; m_cnt[i] = v; m_init[i] = v; m_dir[i] = down;
            end
        end else if (advance) begin
            if (m_cnt[i] == (m_dir[i] ? 0 : LIM)) begin
                d = 1;
                if (P_WRAP[i] != 0) m_cnt[i] = m_init[i];
                else m_run[i] = 0;
            end else if (m_dir[i]) begin
                m_cnt[i] = (m_cnt[i] >= P_STEP[i]) ? m_cnt[i] - P_STEP[i] : 0;
            end else begin
                m_cnt[i] = (m_cnt[i] + P_STEP[i] > LIM) ? LIM : m_cnt[i] + P_STEP[i];
            end
        end
        m_done[i] = d;
    endfunction

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("d%0d.count", i), int'(count_w[i]), m_cnt[i]);
            chk($sformatf("d%0d.busy", i), int'(busy_w[i]), int'(m_run[i]));
            chk($sformatf("d%0d.last", i), int'(last_w[i]),
                int'(m_run[i] && (m_cnt[i] == (m_dir[i] ? 0 : LIM))));
            chk($sformatf("d%0d.done", i), int'(done_w[i]), int'(m_done[i]));
            chk($sformatf("d%0d.zero", i), int'(zero_w[i]), int'(m_cnt[i] == 0));
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        if (reset) model_reset();
        else for (int i = 0; i < N; i++) model_step(i);
        @(negedge clock);
        compare_all();
    endtask

    task automatic drive(input bit st, input int lv, input bit dn, input bit adv, input bit ab);
        start = st; load_val = 7'(lv); down = dn; advance = adv; abort = ab;
    endtask

    typedef struct {
        int st, lv, dn, adv, ab;
        int e_cnt, e_busy, e_last, e_done, e_zero;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int dones;
        int first_done;

        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clock);
        compare_all();
        reset = 1'b0;

        // STEP=2 instance: down pass 5,3,1,0 then abort+start, then clamped up load.
        tbl[0] = '{1,   5, 1, 0, 0,  5, 1, 0, 0, 0};
        tbl[1] = '{0,   5, 1, 1, 0,  3, 1, 0, 0, 0};
        tbl[2] = '{0,   5, 1, 1, 0,  1, 1, 0, 0, 0};
        tbl[3] = '{0,   5, 1, 1, 0,  0, 1, 1, 0, 1};
        tbl[4] = '{0,   5, 1, 1, 0,  0, 0, 0, 1, 1};
        tbl[5] = '{0,   5, 1, 0, 0,  0, 0, 0, 0, 1};
        tbl[6] = '{1,   9, 0, 0, 1,  0, 0, 0, 0, 1};
        tbl[7] = '{1, 100, 0, 0, 0, 63, 1, 1, 0, 0};
        tbl[8] = '{0, 100, 0, 1, 0, 63, 0, 0, 1, 0};
        tbl[9] = '{0,   0, 0, 0, 0, 63, 0, 0, 0, 0};
        for (int k = 0; k < 10; k++) begin
            drive(tbl[k].st[0], tbl[k].lv, tbl[k].dn[0], tbl[k].adv[0], tbl[k].ab[0]);
            cycle();
            chk($sformatf("tbl%0d.count", k), int'(count_w[1]), tbl[k].e_cnt);
            chk($sformatf("tbl%0d.busy", k), int'(busy_w[1]), tbl[k].e_busy);
            chk($sformatf("tbl%0d.last", k), int'(last_w[1]), tbl[k].e_last);
            chk($sformatf("tbl%0d.done", k), int'(done_w[1]), tbl[k].e_done);
            chk($sformatf("tbl%0d.zero", k), int'(zero_w[1]), tbl[k].e_zero);
        end

        // Full up pass 0..63 on the base instance with advance held.
        drive(0, 0, 0, 0, 1); cycle();
        drive(1, 0, 0, 1, 0); cycle();
        chk("upA.start_count", int'(count_w[0]), 0);
        start = 1'b0;
        for (int k = 1; k <= 63; k++) begin
            cycle();
            chk("upA.count", int'(count_w[0]), k);
            chk("upA.last", int'(last_w[0]), int'(k == 63));
            chk("upA.done", int'(done_w[0]), 0);
        end
        cycle();
        chk("upA.done_pulse", int'(done_w[0]), 1);
        chk("upA.busy_fall", int'(busy_w[0]), 0);
        chk("upA.count_held", int'(count_w[0]), 63);
        advance = 1'b0;
        cycle();
        chk("upA.done_single", int'(done_w[0]), 0);

        // Advance every other cycle with start held during RUN: pass takes twice as long.
        drive(0, 0, 0, 0, 1); cycle();
        drive(1, 58, 0, 0, 0); cycle();
        first_done = -1;
        for (int i = 1; i <= 16; i++) begin
            drive(i <= 8, 58, 0, i[0], 0);
            cycle();
            if (done_w[0] && first_done < 0) first_done = i;
        end
        chk("halfrate.done_cycle", first_done, 11);

        // Wrap instance: 60..63 repeats, one done per pass, abort holds count.
        drive(0, 0, 0, 0, 1); cycle();
        drive(1, 60, 0, 0, 0); cycle();
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            drive(0, 60, 0, 1, 0);
            cycle();
            chk("wrap.busy", int'(busy_w[2]), 1);
            if (done_w[2]) dones++;
        end
        chk("wrap.done_count", dones, 3);
        chk("wrap.count", int'(count_w[2]), 60);
        drive(0, 0, 0, 1, 1); cycle();
        chk("wrap.abort_busy", int'(busy_w[2]), 0);
        chk("wrap.abort_count", int'(count_w[2]), 60);
        chk("wrap.abort_done", int'(done_w[2]), 0);

        // Abort mid-pass, then async reset mid-pass.
        drive(1, 10, 0, 0, 0); cycle();
        drive(0, 10, 0, 1, 0); repeat (3) cycle();
        drive(0, 10, 0, 1, 1); cycle();
        chk("abort.count_held", int'(count_w[0]), 13);
        chk("abort.busy", int'(busy_w[0]), 0);
        drive(1, 20, 0, 0, 0); cycle();
        drive(0, 20, 0, 1, 0); repeat (2) cycle();
        #2;
        reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("arst.d%0d.count", i), int'(count_w[i]), 0);
            chk($sformatf("arst.d%0d.zero", i), int'(zero_w[i]), 1);
            chk($sformatf("arst.d%0d.busy", i), int'(busy_w[i]), 0);
        end
        model_reset();
        cycle();
        reset = 1'b0;
        cycle();
        chk("arst.no_done", int'(done_w[0]), 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            drive($urandom_range(0, 3) == 0, int'($urandom_range(0, 127)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
